// File: rtl/seq_tracker.sv
// Receive-side decoder for the WXYZ stepper phase stream: classifies each code into
// one of eight phases, infers direction, tracks signed position, lock and errors.
module seq_tracker #(
    parameter int POS_W      = 8,
    parameter int LOCK_STEPS = 2,
    parameter int ERR_W      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [3:0]       wxyz,
    output logic [2:0]       phase,
    output logic             dir,
    output logic             locked,
    output logic             step_pulse,
    output logic [POS_W-1:0] position,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [2:0] LOCK_CNT = 3'(LOCK_STEPS);

    state_t             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic               dir_q, dir_d;
    logic               locked_q, locked_d;
    logic               step_pulse_q, step_pulse_d;
    logic               err_pulse_q, err_pulse_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [2:0]         streak_q, streak_d;

    logic               code_zero;
    logic               code_legal;
    logic [2:0]         new_phase;
    logic [2:0]         delta;
    logic               is_step;
    logic               is_skip;
    logic               step_dir;
    logic [POS_W-1:0]   pos_stepped;
    logic [ERR_W-1:0]   err_count_inc;
    logic [2:0]         streak_acq;

    // Phase decode of the incoming code
    always_comb begin
        code_zero  = 1'b0;
        code_legal = 1'b1;
        new_phase  = 3'd0;
        case (wxyz)
            4'd0:    code_zero = 1'b1;
            4'd8:    new_phase = 3'd0;
            4'd12:   new_phase = 3'd1;
            4'd4:    new_phase = 3'd2;
            4'd6:    new_phase = 3'd3;
            4'd2:    new_phase = 3'd4;
            4'd3:    new_phase = 3'd5;
            4'd1:    new_phase = 3'd6;
            4'd9:    new_phase = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // 3-bit subtraction gives the modulo-8 phase distance directly
    always_comb begin
        delta         = new_phase - phase_q;
        is_step       = (delta == 3'd1) || (delta == 3'd7);
        is_skip       = (delta != 3'd0) && !is_step;
        step_dir      = (delta == 3'd7);
        pos_stepped   = step_dir ? (position_q - POS_W'(1)) : (position_q + POS_W'(1));
        err_count_inc = (err_count_q == '1) ? err_count_q : (err_count_q + ERR_W'(1));
        streak_acq    = ((streak_q == 3'd0) || (step_dir == dir_q)) ? (streak_q + 3'd1) : 3'd1;
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        dir_d        = dir_q;
        locked_d     = locked_q;
        position_d   = position_q;
        err_count_d  = err_count_q;
        streak_d     = streak_q;
        step_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;

        if (sample_en) begin
            if (code_zero) begin
                state_d  = ST_IDLE;
                locked_d = 1'b0;
                streak_d = 3'd0;
            end else if (!code_legal) begin
                err_pulse_d = 1'b1;
                err_count_d = err_count_inc;
                locked_d    = 1'b0;
                streak_d    = 3'd0;
                state_d     = ST_FAULT;
            end else begin
                case (state_q)
                    ST_IDLE, ST_FAULT: begin
                        phase_d  = new_phase;
                        streak_d = 3'd0;
                        state_d  = ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (is_step) begin
                            step_pulse_d = 1'b1;
                            position_d   = pos_stepped;
                            phase_d      = new_phase;
                            dir_d        = step_dir;
                            streak_d     = streak_acq;
                            if (streak_acq >= LOCK_CNT) begin
                                locked_d = 1'b1;
                                state_d  = ST_LOCKED;
                            end
                        end else if (is_skip) begin
                            phase_d  = new_phase;
                            streak_d = 3'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (is_step) begin
                            step_pulse_d = 1'b1;
                            position_d   = pos_stepped;
                            phase_d      = new_phase;
                            if (step_dir != dir_q) begin
                                dir_d = step_dir;
                                // A single-step lock threshold is met again by the reversing step itself
                                if (LOCK_CNT != 3'd1) begin
                                    streak_d = 3'd1;
                                    locked_d = 1'b0;
                                    state_d  = ST_ACQUIRE;
                                end
                            end
                        end else if (is_skip) begin
                            err_pulse_d = 1'b1;
                            err_count_d = err_count_inc;
                            locked_d    = 1'b0;
                            streak_d    = 3'd0;
                            phase_d     = new_phase;
                            state_d     = ST_FAULT;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            dir_q        <= 1'b0;
            locked_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            position_q   <= '0;
            err_count_q  <= '0;
            streak_q     <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            dir_q        <= dir_d;
            locked_q     <= locked_d;
            step_pulse_q <= step_pulse_d;
            err_pulse_q  <= err_pulse_d;
            position_q   <= position_d;
            err_count_q  <= err_count_d;
            streak_q     <= streak_d;
        end
    end

    assign phase      = phase_q;
    assign dir        = dir_q;
    assign locked     = locked_q;
    assign step_pulse = step_pulse_q;
    assign position   = position_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_seq_tracker.sv
// Self-checking bench for seq_tracker: directed scenarios plus randomized stream,
// all compared against an integer-level reference model.
module tb_seq_tracker;

    localparam int POS_W      = 8;
    localparam int LOCK_STEPS = 2;
    localparam int ERR_W      = 4;
    localparam int POS_MASK   = (1 << POS_W) - 1;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             sample_en;
    logic [3:0]       wxyz;
    logic [2:0]       phase;
    logic             dir;
    logic             locked;
    logic             step_pulse;
    logic [POS_W-1:0] position;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    seq_tracker #(
        .POS_W      (POS_W),
        .LOCK_STEPS (LOCK_STEPS),
        .ERR_W      (ERR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_en  (sample_en),
        .wxyz       (wxyz),
        .phase      (phase),
        .dir        (dir),
        .locked     (locked),
        .step_pulse (step_pulse),
        .position   (position),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .state      (state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // reference model (0=IDLE 1=ACQUIRE 2=LOCKED 3=FAULT)
    int m_state, m_phase, m_dir, m_locked, m_streak, m_pos, m_errc, m_step, m_err;
    int phase_code[8] = '{8, 12, 4, 6, 2, 3, 1, 9};
    int illegal_code[7] = '{5, 7, 10, 11, 13, 14, 15};
    int step_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // returns 0..7 for a phase, 8 for the idle code, 9 for an illegal code
    function automatic int decode(input logic [3:0] c);
        for (int i = 0; i < 8; i++)
            if (int'(c) == phase_code[i]) return i;
        return (c == 4'd0) ? 8 : 9;
    endfunction

    task automatic bump_err();
        m_err = 1;
        if (m_errc < ERR_MAX) m_errc++;
    endtask

    task automatic model(input logic rst, input logic en, input logic [3:0] code);
        int np, d, sd;
        m_step = 0;
        m_err  = 0;
        if (rst) begin
            m_state = 0; m_phase = 0; m_dir = 0; m_locked = 0;
            m_streak = 0; m_pos = 0; m_errc = 0;
            return;
        end
        if (!en) return;
        np = decode(code);
        if (np == 8) begin
            m_state = 0; m_locked = 0; m_streak = 0;
        end else if (np == 9) begin
            bump_err();
            m_locked = 0; m_streak = 0; m_state = 3;
        end else if (m_state == 0 || m_state == 3) begin
            m_phase = np; m_streak = 0; m_state = 1;
        end else begin
            d  = (np - m_phase + 8) % 8;
            sd = (d == 7) ? 1 : 0;
            if (d == 1 || d == 7) begin
                m_step  = 1;
                m_pos   = (m_pos + ((sd != 0) ? -1 : 1)) & POS_MASK;
                m_phase = np;
                if (m_state == 1) begin
                    m_streak = (m_streak == 0 || sd == m_dir) ? m_streak + 1 : 1;
                    m_dir = sd;
                    if (m_streak >= LOCK_STEPS) begin
                        m_state = 2; m_locked = 1;
                    end
                end else if (sd != m_dir) begin
                    m_dir = sd;
                    if (LOCK_STEPS != 1) begin
                        m_streak = 1; m_locked = 0; m_state = 1;
                    end
                end
            end else if (d != 0) begin
                m_phase = np;
                m_streak = 0;
                if (m_state == 2) begin
                    bump_err();
                    m_locked = 0; m_state = 3;
                end
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic [3:0] code);
        reset = rst; sample_en = en; wxyz = code;
        @(posedge clock);
        model(rst, en, code);
        #1;
        if (step_pulse === 1'b1) step_seen++;
        check_eq("state",      32'(state),      32'(m_state));
        check_eq("phase",      32'(phase),      32'(m_phase));
        check_eq("dir",        32'(dir),        32'(m_dir));
        check_eq("locked",     32'(locked),     32'(m_locked));
        check_eq("step_pulse", 32'(step_pulse), 32'(m_step));
        check_eq("position",   32'(position),   32'(m_pos));
        check_eq("err_pulse",  32'(err_pulse),  32'(m_err));
        check_eq("err_count",  32'(err_count),  32'(m_errc));
    endtask

    task automatic smp(input logic [3:0] code);
        cyc(1'b0, 1'b1, code);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 4'd0);
        step_seen = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, p, walk;
        reset = 1'b1; sample_en = 1'b0; wxyz = 4'd0; step_seen = 0;
        do_reset();
        do_reset();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pos",   32'(position), 32'd0);
        check_eq("rst_errc",  32'(err_count), 32'd0);

        // forward lock
        smp(4'd0);
        smp(4'd8);  check_eq("fwd_acq", 32'(state), 32'd1);
        smp(4'd12);
        smp(4'd4);  check_eq("fwd_lock", 32'(locked), 32'd1);
        smp(4'd6); smp(4'd2); smp(4'd3); smp(4'd1); smp(4'd9); smp(4'd8);
        check_eq("fwd_steps", 32'(step_seen), 32'd8);
        check_eq("fwd_pos",   32'(position), 32'd8);
        check_eq("fwd_dir",   32'(dir), 32'd0);
        check_eq("fwd_phase", 32'(phase), 32'd0);
        check_eq("fwd_errc",  32'(err_count), 32'd0);

        // reverse
        do_reset();
        smp(4'd0); smp(4'd9); smp(4'd1);
        smp(4'd3);  check_eq("rev_lock", 32'(locked), 32'd1);
        check_eq("rev_dir", 32'(dir), 32'd1);
        smp(4'd2); smp(4'd6); smp(4'd4); smp(4'd12); smp(4'd8);
        check_eq("rev_pos",   32'(position), 32'hF9);
        check_eq("rev_phase", 32'(phase), 32'd0);

        // illegal code while locked
        do_reset();
        smp(4'd8); smp(4'd12); smp(4'd4); smp(4'd6);
        smp(4'b0101);
        check_eq("ill_err",   32'(err_pulse), 32'd1);
        check_eq("ill_errc",  32'(err_count), 32'd1);
        check_eq("ill_lock",  32'(locked), 32'd0);
        check_eq("ill_state", 32'(state), 32'd3);
        check_eq("ill_phase", 32'(phase), 32'd3);
        smp(4'd2);
        check_eq("ill_rec_state", 32'(state), 32'd1);
        check_eq("ill_rec_phase", 32'(phase), 32'd4);
        check_eq("ill_rec_step",  32'(step_pulse), 32'd0);
        check_eq("ill_rec_err",   32'(err_pulse), 32'd0);

        // skip while locked vs. while acquiring
        do_reset();
        smp(4'd8); smp(4'd12); smp(4'd4); smp(4'd2);
        check_eq("skipL_err",   32'(err_pulse), 32'd1);
        check_eq("skipL_state", 32'(state), 32'd3);
        check_eq("skipL_phase", 32'(phase), 32'd4);
        do_reset();
        smp(4'd8); smp(4'd12); smp(4'd2);
        check_eq("skipA_err",   32'(err_pulse), 32'd0);
        check_eq("skipA_state", 32'(state), 32'd1);

        // hold and gating
        do_reset();
        smp(4'd9); smp(4'd8); smp(4'd12);
        for (int i = 0; i < 3; i++) begin
            smp(4'd12);
            check_eq("hold_step", 32'(step_pulse), 32'd0);
            check_eq("hold_lock", 32'(locked), 32'd1);
        end
        cyc(1'b0, 1'b0, 4'b1111);
        check_eq("gate_err",   32'(err_pulse), 32'd0);
        check_eq("gate_state", 32'(state), 32'd2);

        // saturation, then reset mid-lock
        for (int i = 0; i < 16; i++) begin
            smp(4'(illegal_code[i % 7]));
            check_eq("sat_pulse", 32'(err_pulse), 32'd1);
        end
        check_eq("sat_errc", 32'(err_count), 32'hF);
        smp(4'd8); smp(4'd12); smp(4'd4);
        check_eq("pre_rst_lock", 32'(locked), 32'd1);
        cyc(1'b1, 1'b1, 4'd6);
        check_eq("mid_rst_state", 32'(state), 32'd0);
        check_eq("mid_rst_errc",  32'(err_count), 32'd0);
        check_eq("mid_rst_phase", 32'(phase), 32'd0);

        // position wrap at the positive limit and back
        smp(4'd8);
        for (int i = 1; i <= 128; i++) smp(4'(phase_code[i % 8]));
        check_eq("wrap_fwd", 32'(position), 32'(1 << (POS_W - 1)));
        smp(4'(phase_code[7]));
        check_eq("wrap_rev", 32'(position), 32'((1 << (POS_W - 1)) - 1));

        // randomized stream
        do_reset();
        walk = 0;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            p = m_phase;
            if ($urandom_range(0, 49) == 0) walk = 1 - walk;
            if (r < 55)      wxyz = 4'(phase_code[(p + ((walk != 0) ? 7 : 1)) % 8]);
            else if (r < 63) wxyz = 4'(phase_code[(p + ((walk != 0) ? 1 : 7)) % 8]);
            else if (r < 75) wxyz = 4'(phase_code[p]);
            else if (r < 84) wxyz = 4'(phase_code[(p + $urandom_range(2, 6)) % 8]);
            else if (r < 90) wxyz = 4'd0;
            else             wxyz = 4'(illegal_code[$urandom_range(0, 6)]);
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, wxyz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
